spram_bw: RTL and testbench

- Parametrised single-port synchronous RAM, next generation of the team's single-port memory wrapper.
- Inferred behavioural array; no vendor macro.
- Adds per-byte write enables, configurable read latency (1-4) with an output-valid pipeline, selectable write mode and out-of-range address protection.
- Used as backing store for cache data/tag arrays and TLB storage in the MIPS core.

---
 rtl/spram_bw.sv | 169 ++++++++++++++++
 tb/tb_spram_bw.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spram_bw.sv
// Single-port synchronous RAM with per-byte write enables, 1..4 cycle read latency,
// selectable write mode and out-of-range protection. Optional parity: SPRAM_BW_PARITY_EN.
module spram_bw #(
    parameter int    DATA_WIDTH = 32,
    parameter int    BYTE_WIDTH = 8,
    parameter int    DEPTH      = 128,
    parameter int    LATENCY    = 1,
    parameter string WRITE_MODE = "write_first"
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   we,
    input  logic [$clog2(DEPTH)-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]              din,
`ifdef SPRAM_BW_PARITY_EN
    input  logic                               perr_inject,
    output logic [DATA_WIDTH/BYTE_WIDTH-1:0]   perr,
`endif
    output logic [DATA_WIDTH-1:0]              dout,
    output logic                               dout_valid
);

    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam bit WF = (WRITE_MODE == "write_first");
    localparam bit RF = (WRITE_MODE == "read_first");
    localparam bit NC = (WRITE_MODE == "no_change");
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("spram_bw: LATENCY must be in 1..4");
        end
        if (!(WF || RF || NC)) begin : g_bad_mode
            $error("spram_bw: unknown WRITE_MODE");
        end
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("spram_bw: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  in_range;
    logic                  wr_acc;
    logic                  launch;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] new_word;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] pipe_d [LATENCY];
    logic [LATENCY-1:0]    pipe_v;

    // en is a single-cycle request with no backpressure: every en=1, rst=0 edge is an access.
    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign wr_acc   = |we;
    assign launch   = en && !(NC && wr_acc);

    always_comb begin
        old_word = '0;
        if (in_range) begin
            old_word = mem[addr];
        end
        new_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                new_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        rd_word = WF ? new_word : old_word;
        if (!in_range) begin
            rd_word = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && en && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (we[i]) begin
                    mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Stage 0 is the array output register; later stages only advance when carrying a read,
    // so the last stage doubles as the hold register for dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_d[k] <= '0;
            end
        end else begin
            pipe_v[0] <= launch;
            if (launch) begin
                pipe_d[0] <= rd_word;
            end
            for (int k = 1; k < LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                if (pipe_v[k-1]) begin
                    pipe_d[k] <= pipe_d[k-1];
                end
            end
        end
    end

    assign dout       = pipe_d[LATENCY-1];
    assign dout_valid = pipe_v[LATENCY-1];

`ifdef SPRAM_BW_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];
    logic [NB-1:0] old_par;
    logic [NB-1:0] new_par;
    logic [NB-1:0] rd_perr;
    logic [NB-1:0] pipe_p [LATENCY];

    // Stored bit makes each lane even; an injected write stores the inverted bit.
    always_comb begin
        old_par = '0;
        if (in_range) begin
            old_par = mem_par[addr];
        end
        new_par = old_par;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                new_par[i] = (^din[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ perr_inject;
            end
        end
        rd_perr = '0;
        for (int i = 0; i < NB; i++) begin
            if (WF) begin
                rd_perr[i] = (^new_word[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ new_par[i];
            end else begin
                rd_perr[i] = (^old_word[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ old_par[i];
            end
        end
        if (!in_range) begin
            rd_perr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && en && in_range) begin
            mem_par[addr] <= new_par;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_p[k] <= '0;
            end
        end else begin
            if (launch) begin
                pipe_p[0] <= rd_perr;
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (pipe_v[k-1]) begin
                    pipe_p[k] <= pipe_p[k-1];
                end
            end
        end
    end

    assign perr = pipe_v[LATENCY-1] ? pipe_p[LATENCY-1] : '0;
`endif

endmodule

// File: tb/tb_spram_bw.sv
// Bench for spram_bw: three instances (write_first/DEPTH 100/LAT 2, read_first/LAT 4,
// no_change/LAT 3) share one stimulus stream and are scored against a word-level memory model.
module tb_spram_bw;

    typedef struct {
        int          due;
        logic        dc;
        logic [31:0] d;
        logic [3:0]  p;
    } exp_t;

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [6:0]  addr;
        logic [31:0] din;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              en;
    logic [3:0]        we;
    logic [6:0]        addr;
    logic [31:0]       din;
    logic [2:0][31:0]  dout_w;
    logic [2:0]        dv_w;
`ifdef SPRAM_BW_PARITY_EN
    logic              perr_inject;
    logic [2:0][3:0]   perr_w;
`endif

    spram_bw #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(100), .LATENCY(2), .WRITE_MODE("write_first")) dut_a (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
`ifdef SPRAM_BW_PARITY_EN
        .perr_inject(perr_inject), .perr(perr_w[0]),
`endif
        .dout(dout_w[0]), .dout_valid(dv_w[0]));

    spram_bw #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(128), .LATENCY(4), .WRITE_MODE("read_first")) dut_b (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
`ifdef SPRAM_BW_PARITY_EN
        .perr_inject(perr_inject), .perr(perr_w[1]),
`endif
        .dout(dout_w[1]), .dout_valid(dv_w[1]));

    spram_bw #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(128), .LATENCY(3), .WRITE_MODE("no_change")) dut_c (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
`ifdef SPRAM_BW_PARITY_EN
        .perr_inject(perr_inject), .perr(perr_w[2]),
`endif
        .dout(dout_w[2]), .dout_valid(dv_w[2]));

    int          cyc;
    int          chk_cnt;
    int          pass_cnt;
    exp_t        sb_q [3][$];
    logic [31:0] hold_d [3];
    logic        hold_dc [3];
    logic [31:0] mem_m [128];
    logic [3:0]  pbad_m [128];
    bit          known_m [128];
    vec_t        vt [14];

    task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            logic ev;
            ev = 1'b0;
            e.dc = hold_dc[k];
            e.d  = hold_d[k];
            e.p  = '0;
            if (sb_q[k].size() > 0 && sb_q[k][0].due == cyc) begin
                e = sb_q[k].pop_front();
                ev = 1'b1;
                hold_d[k]  = e.d;
                hold_dc[k] = e.dc;
            end
            compare($sformatf("dut%0d dout_valid", k), 32'(dv_w[k]), 32'(ev));
            if (!e.dc) compare($sformatf("dut%0d dout", k), dout_w[k], e.d);
`ifdef SPRAM_BW_PARITY_EN
            if (!e.dc) compare($sformatf("dut%0d perr", k), 32'(perr_w[k]), ev ? 32'(e.p) : 32'd0);
`endif
        end
    endtask

    // One clock: drive inputs, predict every instance from the word model, then score.
    task automatic access(input logic r, input logic e, input logic [3:0] w, input logic [6:0] a,
                          input logic [31:0] d, input logic inj, input logic ovr,
                          input logic [31:0] ea, input logic [31:0] eb);
        logic [31:0] old_w, mrg;
        logic [3:0]  old_p, mrg_p;
        exp_t        xa, xb, xc;
        rst = r; en = e; we = w; addr = a; din = d;
`ifdef SPRAM_BW_PARITY_EN
        perr_inject = inj;
`endif
        if (r) begin
            for (int k = 0; k < 3; k++) begin
                sb_q[k].delete();
                hold_d[k]  = '0;
                hold_dc[k] = 1'b0;
            end
        end else if (e) begin
            old_w = mem_m[a];
            old_p = pbad_m[a];
            mrg   = old_w;
            mrg_p = old_p;
            for (int i = 0; i < 4; i++) begin
                if (w[i]) begin
                    mrg[i*8 +: 8] = d[i*8 +: 8];
                    mrg_p[i]      = inj;
                end
            end
            xa.due = cyc + 2; xa.dc = !known_m[a] && (w != 4'hF); xa.d = mrg;   xa.p = mrg_p;
            if (a >= 7'd100) begin
                xa.dc = 1'b0; xa.d = '0; xa.p = '0;
            end
            xb.due = cyc + 4; xb.dc = !known_m[a]; xb.d = old_w; xb.p = old_p;
            xc.due = cyc + 3; xc.dc = !known_m[a]; xc.d = old_w; xc.p = old_p;
            if (ovr) begin
                xa.d = ea; xa.dc = 1'b0;
                xb.d = eb; xb.dc = 1'b0;
                xc.d = eb; xc.dc = 1'b0;
            end
            sb_q[0].push_back(xa);
            sb_q[1].push_back(xb);
            if (w == 4'h0) sb_q[2].push_back(xc);
            mem_m[a]   = mrg;
            pbad_m[a]  = mrg_p;
            known_m[a] = known_m[a] || (w == 4'hF);
        end
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) access(1'b0, 1'b0, 4'h0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic rd(input logic [6:0] a);
        access(1'b0, 1'b1, 4'h0, a, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        cyc = 0; chk_cnt = 0; pass_cnt = 0;
        for (int a = 0; a < 128; a++) begin
            known_m[a] = 1'b0;
            mem_m[a]   = '0;
            pbad_m[a]  = '0;
        end
        for (int k = 0; k < 3; k++) begin
            hold_d[k] = '0;
            hold_dc[k] = 1'b0;
        end

        // expected read data: ea for write_first/DEPTH 100, eb for pre-write word
        vt[0]  = '{1'b1, 4'hF, 7'd5,   32'hDEADBEEF, 32'hDEADBEEF, 32'h05050505};
        vt[1]  = '{1'b1, 4'h0, 7'd5,   32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 4'hF, 7'd9,   32'h11223344, 32'h11223344, 32'h09090909};
        vt[3]  = '{1'b1, 4'h5, 7'd9,   32'hAABBCCDD, 32'h11BB33DD, 32'h11223344};
        vt[4]  = '{1'b1, 4'h0, 7'd9,   32'h0,        32'h11BB33DD, 32'h11BB33DD};
        vt[5]  = '{1'b1, 4'hF, 7'd3,   32'h0,        32'h00000000, 32'h03030303};
        vt[6]  = '{1'b1, 4'hF, 7'd3,   32'h12345678, 32'h12345678, 32'h00000000};
        vt[7]  = '{1'b1, 4'h0, 7'd3,   32'h0,        32'h12345678, 32'h12345678};
        vt[8]  = '{1'b1, 4'hF, 7'd120, 32'hFFFFFFFF, 32'h00000000, 32'h78787878};
        vt[9]  = '{1'b1, 4'h0, 7'd120, 32'h0,        32'h00000000, 32'hFFFFFFFF};
        vt[10] = '{1'b1, 4'h0, 7'd20,  32'h0,        32'h14141414, 32'h14141414};
        vt[11] = '{1'b0, 4'hF, 7'd20,  32'h0,        32'h0,        32'h0};
        vt[12] = '{1'b1, 4'h0, 7'd20,  32'h0,        32'h14141414, 32'h14141414};
        vt[13] = '{1'b1, 4'h0, 7'd0,   32'h0,        32'h00000000, 32'h00000000};

        access(1'b1, 1'b0, 4'h0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        access(1'b1, 1'b0, 4'h0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        for (int a = 0; a < 128; a++)
            access(1'b0, 1'b1, 4'hF, 7'(a), 32'h01010101 * 32'(a), 1'b0, 1'b0, 32'd0, 32'd0);
        idle(5);

        for (int i = 0; i < 14; i++)
            access(1'b0, vt[i].en, vt[i].we, vt[i].addr, vt[i].din, 1'b0, 1'b1, vt[i].ea, vt[i].eb);
        idle(5);

        for (int a = 0; a < 8; a++) rd(7'(a));
        idle(6);

        // reads in flight when reset hits, plus a write on the reset edge that must be dropped
        rd(7'd1);
        rd(7'd2);
        access(1'b1, 1'b1, 4'hF, 7'd20, 32'hBAADF00D, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(6);
        rd(7'd20);
        rd(7'd1);
        idle(5);

`ifdef SPRAM_BW_PARITY_EN
        access(1'b0, 1'b1, 4'h2, 7'd7, 32'h0000A500, 1'b1, 1'b0, 32'd0, 32'd0);
        rd(7'd7);
        idle(5);
`endif

        for (int i = 0; i < 400; i++) begin
            logic r_b, e_b, inj_b;
            logic [3:0] w_b;
            r_b   = ($urandom_range(0, 63) == 0);
            e_b   = ($urandom_range(0, 3) != 0);
            w_b   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            inj_b = ($urandom_range(0, 7) == 0);
            access(r_b, e_b, w_b, 7'($urandom_range(0, 127)), $urandom, inj_b, 1'b0, 32'd0, 32'd0);
        end
        idle(8);
        for (int k = 0; k < 3; k++)
            compare($sformatf("dut%0d pending reads", k), 32'(sb_q[k].size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
